// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and helpers for the 3-digit
// 7-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    UPDATE
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [1:0] DIG_ONE = 2'd0;
  localparam logic [1:0] DIG_TEN = 2'd1;
  localparam logic [1:0] DIG_HUN = 2'd2;

  // Active-low pattern, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(
    input logic [3:0] n
  );
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h18;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/status handshake and display pins
// of the segment scan controller.
interface seg_scan_ctrl_if;

  logic [7:0] bin_in;
  logic       load;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic [2:0] an;

  modport master (
    output bin_in,
    output load,
    input  busy,
    input  done,
    input  seg,
    input  an
  );

  modport slave (
    input  bin_in,
    input  load,
    output busy,
    output done,
    output seg,
    output an
  );

endinterface

// File: rtl/seg_scan_ctrl_bcd_seq_conv.sv
// Sequential shift-add-3 binary to BCD engine,
// one iteration per cycle.
module bcd_seq_conv
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds
);

  state_t      state;
  state_t      state_nx;
  logic [19:0] sr;
  logic [19:0] sr_nx;
  logic [19:0] adj;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nx;

  function automatic logic [3:0] add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign adj = {add3(sr[19:16]),
                add3(sr[15:12]),
                add3(sr[11:8]),
                sr[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          sr_nx    = {12'd0, bin};
          cnt_nx   = 3'd0;
          state_nx = CONV;
        end
      end
      CONV: begin
        busy   = 1'b1;
        sr_nx  = {adj[18:0], 1'b0};
        cnt_nx = cnt + 3'd1;
        if (cnt == 3'd7) state_nx = UPDATE;
      end
      UPDATE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign hundreds = sr[19:16];
  assign tens     = sr[15:12];
  assign ones     = sr[11:8];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 3-digit 7-segment controller: BCD conversion
// plus time-multiplexed active-low digit scan.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 4,
  parameter int LZB       = 1
) (
  input logic           clk,
  input logic           rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_BLK = PW'(BLANK_CYC);

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [3:0]    d_one, d_ten, d_hun;
  logic [3:0]    c_one, c_ten, c_hun;
  logic          conv_done;
  logic [3:0]    nib;
  logic          blank;
  logic          win;
  logic [6:0]    seg_nx, seg_q;
  logic [2:0]    an_nx, an_q;

  bcd_seq_conv u_conv (
    .clk      (clk),
    .rst      (rst),
    .start    (bus.load),
    .bin      (bus.bin_in),
    .busy     (bus.busy),
    .done     (conv_done),
    .ones     (c_one),
    .tens     (c_ten),
    .hundreds (c_hun)
  );

  assign bus.done = conv_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      idx   <= DIG_ONE;
      d_one <= '0;
      d_ten <= '0;
      d_hun <= '0;
      seg_q <= SEG_OFF;
      an_q  <= 3'b111;
    end else begin
      if (pre == PRE_MAX) begin
        pre <= '0;
        idx <= (idx == DIG_HUN) ? DIG_ONE
                                : idx + 2'd1;
      end else begin
        pre <= pre + 1'b1;
      end
      // Digits only change on done: no partial values
      if (conv_done) begin
        d_one <= c_one;
        d_ten <= c_ten;
        d_hun <= c_hun;
      end
      seg_q <= seg_nx;
      an_q  <= an_nx;
    end
  end

  always_comb begin
    nib   = d_one;
    blank = 1'b0;
    unique case (idx)
      DIG_ONE: nib = d_one;
      DIG_TEN: begin
        nib   = d_ten;
        blank = (LZB != 0) && (d_hun == 4'd0)
                && (d_ten == 4'd0);
      end
      DIG_HUN: begin
        nib   = d_hun;
        blank = (LZB != 0) && (d_hun == 4'd0);
      end
      default: blank = 1'b1;
    endcase
  end

  assign win = (pre < PRE_BLK);

  always_comb begin
    seg_nx = SEG_OFF;
    an_nx  = 3'b111;
    if (!blank && !win) begin
      seg_nx = seg_decode(nib);
      an_nx  = ~(3'b001 << idx);
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with
// an LZB=1 and an LZB=0 instance in lockstep.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seg_scan_ctrl_if b1 ();
  seg_scan_ctrl_if b0 ();

  seg_scan_ctrl #(
    .SCAN_DIV (4),
    .BLANK_CYC(1),
    .LZB      (1)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(b1.slave)
  );

  seg_scan_ctrl #(
    .SCAN_DIV (4),
    .BLANK_CYC(1),
    .LZB      (0)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(b0.slave)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  logic [6:0] tbl [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h18
  };

  task automatic drive(input bit ld,
                       input logic [7:0] v);
    b1.load   = ld;
    b1.bin_in = v;
    b0.load   = ld;
    b0.bin_in = v;
  endtask

  function automatic void exp_disp(
    input  int v,
    input  bit lzb,
    output logic [2:0][6:0] s,
    output logic [2:0] lit
  );
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    lit[0] = 1'b1;
    lit[1] = !lzb || h != 0 || t != 0;
    lit[2] = !lzb || h != 0;
    s[0] = tbl[o];
    s[1] = tbl[t];
    s[2] = tbl[h];
  endfunction

  task automatic observe(
    output logic [2:0][6:0] s1,
    output logic [2:0][6:0] s0,
    output logic [2:0] l1,
    output logic [2:0] l0,
    output int bad
  );
    s1 = '1; s0 = '1; l1 = '0; l0 = '0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (b1.an[k] == 1'b0) begin
          l1[k] = 1'b1;
          s1[k] = b1.seg;
        end
        if (b0.an[k] == 1'b0) begin
          l0[k] = 1'b1;
          s0[k] = b0.seg;
        end
      end
      if ($countones(~b1.an) > 1) bad++;
      if ($countones(~b0.an) > 1) bad++;
      if (b1.an == 3'b111 && b1.seg != 7'h7F) bad++;
      if (b0.an == 3'b111 && b0.seg != 7'h7F) bad++;
    end
  endtask

  task automatic check_disp(input string nm,
                            input int v);
    logic [2:0][6:0] s1, s0, e1, e0;
    logic [2:0] l1, l0, el1, el0;
    int bad;
    observe(s1, s0, l1, l0, bad);
    exp_disp(v, 1'b1, e1, el1);
    exp_disp(v, 1'b0, e0, el0);
    checks++;
    if (l1 !== el1) begin
      errors++;
      $display("FAIL %s lzb1 lit got %b want %b",
               nm, l1, el1);
    end
    checks++;
    if (l0 !== el0) begin
      errors++;
      $display("FAIL %s lzb0 lit got %b want %b",
               nm, l0, el0);
    end
    for (int k = 0; k < 3; k++) begin
      if (el1[k]) begin
        checks++;
        if (s1[k] !== e1[k]) begin
          errors++;
          $display("FAIL %s lzb1 dig%0d got %h want %h",
                   nm, k, s1[k], e1[k]);
        end
      end
      checks++;
      if (s0[k] !== e0[k]) begin
        errors++;
        $display("FAIL %s lzb0 dig%0d got %h want %h",
                 nm, k, s0[k], e0[k]);
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s scan_glitch got %0d want 0",
               nm, bad);
    end
  endtask

  // Called at a negedge with FSM idle; returns
  // at the negedge of cycle t+1.
  task automatic start_conv(input string nm,
                            input int v,
                            input bit push);
    drive(1'b1, 8'(v));
    if (push) exp_q.push_back(v);
    @(negedge clk);
    drive(1'b0, 8'd0);
    checks++;
    if (b1.busy !== 1'b1 || b0.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_t1 got %b%b want 11",
               nm, b1.busy, b0.busy);
    end
  endtask

  task automatic wait_done(input string nm,
                           output int v);
    int k = 1;
    v = -1;
    while (b1.done !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 9 || b0.done !== 1'b1
        || b1.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s done_lat got %0d want 9",
               nm, k);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard got empty want 1",
               nm);
    end else begin
      v = exp_q.pop_front();
    end
    @(negedge clk);
    checks++;
    if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_t10 got %b%b want 00",
               nm, b1.busy, b1.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (b1.busy !== 1'b0 || b1.done !== 1'b0
        || b0.busy !== 1'b0 || b0.done !== 1'b0) begin
      errors++;
      $display("FAIL reset busy_done got %b%b want 00",
               b1.busy, b1.done);
    end
    checks++;
    if (b1.seg !== 7'h7F || b0.seg !== 7'h7F) begin
      errors++;
      $display("FAIL reset seg got %h want 7f",
               b1.seg);
    end
    checks++;
    if (b1.an !== 3'b111 || b0.an !== 3'b111) begin
      errors++;
      $display("FAIL reset an got %b want 111",
               b1.an);
    end
    rst = 1'b0;
    @(negedge clk);
    check_disp("reset_disp", 0);
  endtask

  task automatic test_value(input string nm,
                            input int v);
    int got;
    start_conv(nm, v, 1'b1);
    wait_done(nm, got);
    repeat (2) @(negedge clk);
    check_disp(nm, got);
  endtask

  task automatic test_busy_ignore();
    int nd = 0;
    int kd = 0;
    int got;
    start_conv("ignore", 123, 1'b1);
    for (int k = 2; k <= 25; k++) begin
      @(negedge clk);
      if (k == 3) drive(1'b1, 8'd45);
      if (k == 4) drive(1'b0, 8'd0);
      if (b1.done === 1'b1) begin
        nd++;
        kd = k;
      end
    end
    checks++;
    if (nd != 1 || kd != 9) begin
      errors++;
      $display("FAIL ignore done got %0d@%0d want 1@9",
               nd, kd);
    end
    checks++;
    if (b1.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore busy got %b want 0",
               b1.busy);
    end
    got = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    check_disp("ignore", got);
  endtask

  task automatic test_reset_mid_and_scan();
    logic [2:0] ea1, ea0;
    logic [6:0] es1, es0;
    int p;
    start_conv("rstmid", 200, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (b1.seg !== 7'h7F || b1.an !== 3'b111
        || b1.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid regs got %h %b want 7f 111",
               b1.seg, b1.an);
    end
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      p = k % 12;
      if (p % 4 == 0) begin
        ea0 = 3'b111;
        es0 = 7'h7F;
      end else begin
        ea0 = ~(3'b001 << (p / 4));
        es0 = 7'h40;
      end
      ea1 = (p / 4 == 0) ? ea0 : 3'b111;
      es1 = (p / 4 == 0) ? es0 : 7'h7F;
      checks++;
      if (b0.an !== ea0 || b0.seg !== es0) begin
        errors++;
        $display("FAIL scan0 c%0d got %b %h want %b %h",
                 k, b0.an, b0.seg, ea0, es0);
      end
      checks++;
      if (b1.an !== ea1 || b1.seg !== es1) begin
        errors++;
        $display("FAIL scan1 c%0d got %b %h want %b %h",
                 k, b1.an, b1.seg, ea1, es1);
      end
      checks++;
      if (b1.done !== 1'b0 || b1.busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid c%0d got %b%b want 00",
                 k, b1.busy, b1.done);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard left got %0d want 0",
               exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'd0);
    @(negedge clk);
    test_reset();
    test_value("max255", 255);
    test_value("zero", 0);
    test_value("seven", 7);
    test_value("hundred", 100);
    test_busy_ignore();
    test_reset_mid_and_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
